quad_step_decoder: RTL and testbench

- Upstream stage for the up/down one-hot counter: converts a quadrature encoder (A/B phases plus an index pulse) into the counter's control inputs `cen`, `count_up_dwn`, `load` and `data_preset`.
- Synchronises and glitch-filters the raw asynchronous pins.
- Decodes Gray-code steps into single-cycle count enables with a direction.
- Flags illegal double-phase transitions.

---
 rtl/quad_step_decoder.sv | 82 ++++++++
 tb/tb_quad_step_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature A/B/index front end producing count enable, direction, preset load and illegal-step flag
module quad_step_decoder #(
  parameter int WIDTH = 8,
  parameter int FILT = 2,
  parameter logic [WIDTH-1:0] INDEX_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             quad_idx,
  input  logic             idx_en,
  input  logic             err_clr,
  output logic             cen,
  output logic             count_up_dwn,
  output logic             load,
  output logic [WIDTH-1:0] data_preset,
  output logic             err
);
  localparam int CW = $clog2(FILT + 3);
  localparam logic [CW-1:0] ACC_AT = CW'(FILT - 1);
  localparam logic [CW-1:0] INIT_AT = CW'(FILT + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [2:0] s1, s2;
  logic [1:0] ab_new, ab_last, ab_filt;
  logic idx_last, idx_filt;
  logic [CW-1:0] ab_cnt, idx_cnt, init_cnt;
  logic init;
  logic ab_hold, ab_acc, idx_hold, idx_acc, init_stable;
  logic [1:0] pos_old, pos_new, pos_diff;
  logic step_up, step_dn, illegal;
  assign data_preset = INDEX_VAL;
  always_comb begin
    ab_new = s2[1:0];
    ab_hold = (ab_new == ab_filt) || (ab_new != ab_last);
    ab_acc = !ab_hold && (ab_cnt == ACC_AT);
    idx_hold = (s2[2] == idx_filt) || (s2[2] != idx_last);
    idx_acc = !idx_hold && (idx_cnt == ACC_AT);
    init_stable = (ab_new == ab_filt) && (ab_new == ab_last);
    pos_old = {ab_filt[1], ^ab_filt};
    pos_new = {ab_new[1], ^ab_new};
    pos_diff = pos_new - pos_old;
    step_up = ab_acc && !init && (pos_diff == 2'd1);
    step_dn = ab_acc && !init && (pos_diff == 2'd3);
    illegal = ab_acc && !init && (pos_diff == 2'd2);
  end
  // init holds off decoding until the reset value is confirmed or the first filtered update lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      ab_last <= '0;
      ab_filt <= '0;
      idx_last <= 1'b0;
      idx_filt <= 1'b0;
      ab_cnt <= '0;
      idx_cnt <= '0;
      init_cnt <= '0;
      init <= 1'b1;
      cen <= 1'b0;
      load <= 1'b0;
      count_up_dwn <= 1'b1;
      err <= 1'b0;
    end else begin
      s1 <= {quad_idx, quad_a, quad_b};
      s2 <= s1;
      ab_last <= ab_new;
      idx_last <= s2[2];
      ab_cnt <= (ab_hold || ab_acc) ? '0 : ab_cnt + ONE;
      idx_cnt <= (idx_hold || idx_acc) ? '0 : idx_cnt + ONE;
      ab_filt <= ab_acc ? ab_new : ab_filt;
      idx_filt <= idx_acc ? s2[2] : idx_filt;
      init_cnt <= (init && init_stable) ? init_cnt + ONE : '0;
      init <= init && !ab_acc && !(init_stable && init_cnt == INIT_AT);
      cen <= enable && (step_up || step_dn);
      load <= enable && idx_en && idx_acc && s2[2];
      count_up_dwn <= (enable && (step_up || step_dn)) ? step_up : count_up_dwn;
      err <= illegal || (err && !err_clr);
    end
  end
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: randomized scoreboard bench for the quadrature step decoder
module tb_quad_step_decoder;
  localparam int FILT = 3;
  localparam int LAT = FILT + 3;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, quad_a = 1'b0, quad_b = 1'b0, quad_idx = 1'b0;
  logic idx_en = 1'b0, err_clr = 1'b0;
  logic cen, count_up_dwn, load, err;
  logic [7:0] data_preset;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int cyc; bit cen; bit up; bit load;} ev_t;
  ev_t q[$];
  ev_t m_e;
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] cur_ab = 2'b00;
  logic cur_idx = 1'b0;
  bit err_exp = 1'b0, dir_exp = 1'b1;

  quad_step_decoder #(.WIDTH(8), .FILT(FILT), .INDEX_VAL(8'h5A)) dut (
    .clk(clk), .rst(rst), .enable(enable), .quad_a(quad_a), .quad_b(quad_b),
    .quad_idx(quad_idx), .idx_en(idx_en), .err_clr(err_clr), .cen(cen),
    .count_up_dwn(count_up_dwn), .load(load), .data_preset(data_preset), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int gidx(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (gray[i] == v) return i;
    return 0;
  endfunction

  // a stable pin state is accepted LAT edges after it is first driven
  task automatic apply(input logic [1:0] ab, input logic idx, input int gap);
    ev_t e;
    int d;
    e.cyc = cyc + LAT; e.cen = 1'b0; e.up = 1'b0; e.load = 1'b0;
    if (ab != cur_ab) begin
      d = (gidx(ab) - gidx(cur_ab) + 4) % 4;
      if (d == 2) err_exp = 1'b1;
      else begin e.cen = enable; e.up = (d == 1); end
    end
    e.load = idx && !cur_idx && idx_en && enable;
    if (e.cen || e.load) q.push_back(e);
    cur_ab = ab; cur_idx = idx;
    {quad_a, quad_b} = ab; quad_idx = idx;
    repeat (gap) @(negedge clk);
    chk("err_level", err, err_exp);
  endtask

  task automatic step(input int dir, input int gap);
    apply(gray[(gidx(cur_ab) + dir) % 4], cur_idx, gap);
  endtask

  task automatic glitch(input logic [2:0] mask, input int len, input int gap);
    {quad_idx, quad_a, quad_b} = {cur_idx, cur_ab} ^ mask;
    repeat (len) @(negedge clk);
    {quad_idx, quad_a, quad_b} = {cur_idx, cur_ab};
    repeat (gap) @(negedge clk);
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    chk("err_clr", err, err_exp);
  endtask

  always @(negedge clk) begin
    if (rst) dir_exp = 1'b1;
    else begin
      if (cen || load) begin
        if (q.size() == 0) chk("unexpected_pulse", {cen, load}, 2'b00);
        else begin
          m_e = q.pop_front();
          chk("pulse_cycle", cyc, m_e.cyc);
          chk("pulse_cen", cen, m_e.cen);
          chk("pulse_load", load, m_e.load);
          if (m_e.cen) dir_exp = m_e.up;
        end
      end
      if (q.size() != 0 && q[0].cyc < cyc) begin
        chk("missing_pulse", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      chk("count_up_dwn", count_up_dwn, dir_exp);
    end
  end

  initial begin
    int r, gap;
    #1 rst = 1'b1;
    #2;
    chk("rst_cen", cen, 0);
    chk("rst_load", load, 0);
    chk("rst_err", err, 0);
    chk("rst_dir", count_up_dwn, 1);
    chk("data_preset", data_preset, 8'h5A);
    repeat (3) @(negedge clk);
    rst = 1'b0; enable = 1'b1; idx_en = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) step(1, 10);
    for (int i = 0; i < 4; i++) step(3, 10);
    glitch(3'b010, 1, 8);
    glitch(3'b001, 2, 8);
    step(1, 10);
    step(2, 10);
    clr_err();
    step(2, 10);
    step(2, LAT - 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_set_wins", err, 1);
    repeat (4) @(negedge clk);
    clr_err();
    apply(gray[(gidx(cur_ab) + 1) % 4], 1'b1, 10);
    apply(cur_ab, 1'b0, 10);
    idx_en = 1'b0;
    apply(cur_ab, 1'b1, 10);
    apply(cur_ab, 1'b0, 10);
    idx_en = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 10);
    step(2, 10);
    clr_err();
    enable = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      gap = $urandom_range(LAT + 1, LAT + 6);
      enable = ($urandom_range(0, 3) != 0);
      idx_en = $urandom_range(0, 1) == 1;
      if (r <= 5) step(($urandom_range(0, 1) == 1) ? 1 : 3, gap);
      else if (r == 6) step(2, gap);
      else if (r == 7) glitch(3'($urandom_range(1, 7)), $urandom_range(1, FILT - 1), gap);
      else if (r == 8) apply(cur_ab, !cur_idx, gap);
      else clr_err();
    end
    enable = 1'b1; idx_en = 1'b1;
    apply(cur_ab, 1'b0, 10);
    clr_err();
    apply(gray[(gidx(cur_ab) + 1) % 4], 1'b1, LAT - 1);
    @(posedge clk);
    #1;
    chk("pre_rst_cen", cen, 1);
    chk("pre_rst_load", load, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_cen", cen, 0);
    chk("async_rst_load", load, 0);
    chk("async_rst_dir", count_up_dwn, 1);
    q.delete();
    quad_a = 1'b1; quad_b = 1'b1; quad_idx = 1'b0;
    cur_ab = 2'b11; cur_idx = 1'b0; err_exp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_err", err, 0);
    step(1, 10);
    step(3, 10);
    repeat (10) @(negedge clk);
    chk("queue_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
